// File: rtl/zero_scan_ctrl_pkg.sv
// Shared constants and state encoding for the multi-cycle zero-scan controller.
package zero_scan_ctrl_pkg;

    localparam int CHUNK_W = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/zero_detector.sv
// Existing 64-bit zero detector: is_zero is 1 exactly when the whole chunk is 0.
module zero_detector (
    input  logic [63:0] chunk,
    output logic        is_zero
);

    assign is_zero = (chunk == 64'd0);

endmodule

// File: rtl/zero_scan_ctrl.sv
// Scans a captured wide word one 64-bit chunk per cycle through a single shared
// zero_detector and reports all-zero, first nonzero chunk index and nonzero count.
//
// state | meaning
// IDLE  | waiting for start; start captures the word and early_exit
// SCAN  | shadow chunk[idx] drives the detector; count and first index accumulate
// DONE  | one-cycle done pulse; start here begins the next scan directly
module zero_scan_ctrl
    import zero_scan_ctrl_pkg::*;
#(
    parameter  int NCHUNK = 4,
    parameter  int IDX_W  = $clog2(NCHUNK),
    localparam int DATA_W = NCHUNK * CHUNK_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              early_exit,
    input  logic [DATA_W-1:0] in_data,
    output logic              busy,
    output logic              done,
    output logic              all_zero,
    output logic [IDX_W-1:0]  first_nz_idx,
    output logic [IDX_W:0]    nz_count
);

    state_t state;
    state_t state_next;

    logic [DATA_W-1:0]  shadow;
    logic               early_reg;
    logic [IDX_W-1:0]   idx;
    logic [IDX_W:0]     work_cnt;
    logic [IDX_W-1:0]   first_idx;
    logic               found;

    logic [CHUNK_W-1:0] chunks [NCHUNK];
    logic [CHUNK_W-1:0] chunk_sel;
    logic               is_zero;
    logic               nz;
    logic               last;
    logic               scan_end;
    logic [IDX_W:0]     cnt_next;
    logic [IDX_W-1:0]   first_next;

    for (genvar i = 0; i < NCHUNK; i++) begin : g_chunk
        assign chunks[i] = shadow[i*CHUNK_W +: CHUNK_W];
    end

    assign chunk_sel = chunks[idx];

    zero_detector u_zero_detector (
        .chunk   (chunk_sel),
        .is_zero (is_zero)
    );

    assign nz         = ~is_zero;
    assign last       = (idx == IDX_W'(NCHUNK - 1));
    assign scan_end   = last || (early_reg && nz);
    assign cnt_next   = work_cnt + (IDX_W+1)'(nz);
    assign first_next = found ? first_idx : (nz ? idx : '0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (start) state_next = SCAN;
            SCAN: if (scan_end) state_next = DONE;
            DONE: state_next = start ? SCAN : IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign busy = (state == SCAN);
    assign done = (state == DONE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shadow       <= '0;
            early_reg    <= 1'b0;
            idx          <= '0;
            work_cnt     <= '0;
            first_idx    <= '0;
            found        <= 1'b0;
            all_zero     <= 1'b0;
            first_nz_idx <= '0;
            nz_count     <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        shadow    <= in_data;
                        early_reg <= early_exit;
                        idx       <= '0;
                        work_cnt  <= '0;
                        first_idx <= '0;
                        found     <= 1'b0;
                    end
                end
                SCAN: begin
                    work_cnt <= cnt_next;
                    if (nz && !found) begin
                        first_idx <= idx;
                        found     <= 1'b1;
                    end
                    // Results are published only on the edge that leaves SCAN.
                    if (scan_end) begin
                        all_zero     <= (cnt_next == '0);
                        first_nz_idx <= first_next;
                        nz_count     <= cnt_next;
                    end else begin
                        idx <= idx + IDX_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/zero_scan_ctrl.md
Name: zero_scan_ctrl

Overview:
Multi-cycle zero-scan controller for wide words. It captures a DATA_W-bit word and drives it one 64-bit chunk per cycle through a single shared zero_detector instance. It reports whether the whole word is zero, the index of the first nonzero chunk, and the number of nonzero chunks. It sits between a requesting datapath stage and the existing 64-bit zero_detector, so one detector serves words wider than 64 bits.

Parameters:
NCHUNK, 4, number of 64-bit chunks per word; DATA_W = NCHUNK*64 is derived, so 256 by default; NCHUNK must be at least 2.
IDX_W, $clog2(NCHUNK), width of the chunk index; 2 by default.

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  synchronous active-low reset
start  in  1  request a scan; sampled only when the block is not busy
early_exit  in  1  when 1, stop the scan at the first nonzero chunk; sampled with start
in_data  in  DATA_W  word to scan; sampled with start
busy  out  1  high while scanning
done  out  1  one-cycle pulse; result outputs are valid from this cycle on
all_zero  out  1  1 if every scanned chunk was zero
first_nz_idx  out  IDX_W  index of the lowest-index nonzero chunk; 0 when all_zero=1
nz_count  out  IDX_W+1  number of nonzero chunks found

Behaviour:
- Reset: rst_n=0 at a rising edge forces state IDLE. busy, done, all_zero, first_nz_idx and nz_count all become 0, and every internal register clears.
- Reset mid-scan aborts the scan with no done pulse.
- Chunk ordering: chunk i = in_data[64*i+63 : 64*i]. Chunk 0 is the LSBs and is scanned first.
- States:
  - IDLE: busy=0. start=1 captures in_data into a shadow register, latches early_exit, sets idx=0, clears the working count and first-found flag, then goes to SCAN.
  - SCAN: busy=1. The shadow chunk[idx] drives zero_detector combinationally.
    - On each edge, if the detector output is 0: increment the working count; if the first-found flag is clear, record idx and set the flag.
    - Go to DONE when idx==NCHUNK-1, or when early_exit=1 and the current chunk is nonzero. Otherwise increment idx.
  - DONE: busy=0, done=1 for exactly one cycle. start=1 in this cycle is accepted as in IDLE (back-to-back scans) and goes to SCAN; otherwise go to IDLE.
- Result registers: all_zero, first_nz_idx and nz_count are written only on the SCAN→DONE edge. They are held until the next SCAN→DONE edge.
- Latency, counted from the edge that samples start:
  - Full scan: done is high in the cycle after edge NCHUNK+1 (5 cycles with default NCHUNK).
  - Early exit at chunk j: done follows edge j+2.
- Holding and ignored inputs:
  - start while busy=1 is ignored (no queueing).
  - in_data and early_exit changes after capture have no effect on the running scan.
- Width rules: nz_count saturates naturally, since its maximum is NCHUNK and it fits in IDX_W+1 bits. idx never exceeds NCHUNK-1.

Decomposition:
- Shared package: CHUNK_W=64 constant; state enum {IDLE, SCAN, DONE} typedef, encoded in 2 bits.
- Sub-module: the existing zero_detector (64-bit in, out=1 iff in==0), instantiated once and fed by a mux on the shadow register indexed by idx.
- No other sub-modules.

Test Plan:
1. Defaults; in_data=0, early_exit=0, start one cycle -> busy high 4 cycles, done pulse on 5th cycle; all_zero=1, first_nz_idx=0, nz_count=0.
2. in_data all ones, early_exit=1 -> done 2 cycles after start; all_zero=0, first_nz_idx=0, nz_count=1.
3. Only bit 200 set, early_exit=1 -> full scan with done at cycle 5; all_zero=0, first_nz_idx=3, nz_count=1.
4. Bits 70 and 130 set, early_exit=0 -> done at cycle 5; first_nz_idx=1, nz_count=2.
5. Pulse start again during busy -> ignored, single done. Then assert start in the done cycle with in_data=0 -> second scan starts immediately, its done 5 cycles later with all_zero=1. Changing in_data mid-scan leaves the result unchanged.
6. Start a scan with bit 0 set, then rst_n=0 at cycle 2 -> no done; all outputs 0 on the next edge. The next start after release scans correctly.
